// File: rtl/difftest_commit_monitor_if.sv
// Commit-monitor bus: expected-PC push channel plus the core's commit pulses.
// The loader and the core top together act as master; the monitor is the slave.
interface difftest_commit_monitor_if;
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic        exp_ready;
  logic        commit_en;
  logic [31:0] commit_pc;

  modport master (
    output exp_valid,
    output exp_pc,
    output commit_en,
    output commit_pc,
    input  exp_ready
  );

  modport slave (
    input  exp_valid,
    input  exp_pc,
    input  commit_en,
    input  commit_pc,
    output exp_ready
  );
endinterface

// File: rtl/difftest_commit_monitor.sv
// Difftest commit monitor: checks committed PCs in order against a loaded
// expected-PC FIFO, with sticky pass/fail status and a hang watchdog.
module difftest_commit_monitor #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     resetn,
  difftest_commit_monitor_if.slave bus,
  input  logic                     start,
  input  logic                     finish,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_code,
  output logic [31:0]              mismatch_exp,
  output logic [31:0]              mismatch_got,
  output logic [31:0]              commit_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PASS = 2'd2;
  localparam logic [1:0] FAIL = 2'd3;

  localparam logic [AW:0]   LVL_MAX = DEPTH[AW:0];
  localparam logic [31:0]   WD_MAX  = 32'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   wdog;
  logic [31:0]   head;

  logic empty;
  logic push;
  logic pop;
  logic run;
  logic hit;
  logic empty_hit;
  logic pc_miss;
  logic timeout;
  logic done;

  assign busy = (state == RUN);
  assign pass = (state == PASS);
  assign fail = (state == FAIL);

  assign head  = mem[rd_ptr];
  assign empty = (fifo_level == '0);
  assign run   = (state == RUN);

  assign bus.exp_ready = (fifo_level < LVL_MAX) &&
                         (state == IDLE || state == RUN);

  assign push = bus.exp_valid && bus.exp_ready;

  // Emptiness is judged on the registered level, so a
  // same-cycle push never satisfies a commit.
  assign hit       = run && bus.commit_en;
  assign empty_hit = hit && empty;
  assign pc_miss   = hit && !empty && (head != bus.commit_pc);
  assign pop       = hit && !empty && (head == bus.commit_pc);
  assign timeout   = run && !bus.commit_en && (wdog == WD_MAX);
  assign done      = run && !bus.commit_en && !timeout &&
                     finish && empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.exp_pc;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      fail_code    <= '0;
      mismatch_exp <= '0;
      mismatch_got <= '0;
      commit_cnt   <= '0;
      wdog         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase

      if (pop && commit_cnt != '1)
        commit_cnt <= commit_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            wdog  <= '0;
          end
        end
        RUN: begin
          if (bus.commit_en) wdog <= '0;
          else               wdog <= wdog + 1'b1;

          unique case (1'b1)
            empty_hit: begin
              state        <= FAIL;
              fail_code    <= 2'd2;
              mismatch_exp <= '0;
              mismatch_got <= bus.commit_pc;
            end
            pc_miss: begin
              state        <= FAIL;
              fail_code    <= 2'd1;
              mismatch_exp <= head;
              mismatch_got <= bus.commit_pc;
            end
            timeout: begin
              state        <= FAIL;
              fail_code    <= 2'd3;
              mismatch_exp <= empty ? '0 : head;
              mismatch_got <= '0;
            end
            done: begin
              state <= PASS;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_difftest_commit_monitor.sv
// Bench for difftest_commit_monitor: vector table plus hand sequences,
// checked against a PC scoreboard queue and a small status model.
module tb_difftest_commit_monitor;

  logic clk = 1'b0;
  logic resetn;
  logic start;
  logic finish;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [31:0] mismatch_exp;
  logic [31:0] mismatch_got;
  logic [31:0] commit_cnt;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  difftest_commit_monitor_if bus ();

  difftest_commit_monitor #(
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .start        (start),
    .finish       (finish),
    .busy         (busy),
    .pass         (pass),
    .fail         (fail),
    .fail_code    (fail_code),
    .mismatch_exp (mismatch_exp),
    .mismatch_got (mismatch_got),
    .commit_cnt   (commit_cnt),
    .fifo_level   (fifo_level)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 run, 2 pass, 3 fail
  logic [31:0] sb[$];
  int          m_st;
  logic [1:0]  m_code;
  logic [31:0] m_cnt;
  logic [31:0] m_mexp;
  logic [31:0] m_mgot;

  typedef struct {
    int          np;
    logic [31:0] pp[4];
    int          nc;
    logic [31:0] cp[4];
    bit          fin;
    bit          e_pass;
    bit          e_fail;
    logic [1:0]  e_code;
    logic [31:0] e_cnt;
    int          e_lvl;
    logic [31:0] e_mexp;
    logic [31:0] e_mgot;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    bit rdy;
    rdy = (sb.size() < 4) && (m_st <= 1);
    chk({tag, "/busy"}, 32'(busy), 32'(m_st == 1));
    chk({tag, "/pass"}, 32'(pass), 32'(m_st == 2));
    chk({tag, "/fail"}, 32'(fail), 32'(m_st == 3));
    chk({tag, "/code"}, 32'(fail_code), 32'(m_code));
    chk({tag, "/cnt"}, commit_cnt, m_cnt);
    chk({tag, "/lvl"}, 32'(fifo_level), 32'(sb.size()));
    chk({tag, "/rdy"}, 32'(bus.exp_ready), 32'(rdy));
    chk({tag, "/mexp"}, mismatch_exp, m_mexp);
    chk({tag, "/mgot"}, mismatch_got, m_mgot);
  endtask

  task automatic cyc(input bit pv, input logic [31:0] ppc,
                     input bit cv, input logic [31:0] cpc,
                     input string tag);
    bit rdy;
    rdy = (sb.size() < 4) && (m_st <= 1);
    if (cv && m_st == 1) begin
      if (sb.size() == 0) begin
        m_st = 3; m_code = 2; m_mexp = 0; m_mgot = cpc;
      end else if (sb[0] !== cpc) begin
        m_st = 3; m_code = 1; m_mexp = sb[0]; m_mgot = cpc;
      end else begin
        void'(sb.pop_front());
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end
    end
    if (pv && rdy) sb.push_back(ppc);
    bus.exp_valid = pv;
    bus.exp_pc    = ppc;
    bus.commit_en = cv;
    bus.commit_pc = cpc;
    tick();
    bus.exp_valid = 1'b0;
    bus.commit_en = 1'b0;
    chk_state(tag);
  endtask

  task automatic start_run(input string tag);
    start = 1'b1;
    if (m_st == 0) m_st = 1;
    tick();
    start = 1'b0;
    chk_state(tag);
  endtask

  task automatic do_finish(input string tag);
    finish = 1'b1;
    if (m_st == 1 && sb.size() == 0) m_st = 2;
    tick();
    finish = 1'b0;
    chk_state(tag);
  endtask

  task automatic do_reset(input string tag);
    resetn        = 1'b0;
    start         = 1'b0;
    finish        = 1'b0;
    bus.exp_valid = 1'b0;
    bus.exp_pc    = '0;
    bus.commit_en = 1'b0;
    bus.commit_pc = '0;
    tick();
    resetn = 1'b1;
    sb.delete();
    m_st = 0; m_code = 0; m_cnt = 0;
    m_mexp = 0; m_mgot = 0;
    chk_state(tag);
  endtask

  task automatic run_vec(input int i);
    string t;
    t = $sformatf("vec%0d", i);
    do_reset({t, "/rst"});
    for (int k = 0; k < tbl[i].np; k++)
      cyc(1'b1, tbl[i].pp[k], 1'b0, '0, {t, "/push"});
    start_run({t, "/start"});
    for (int k = 0; k < tbl[i].nc; k++)
      cyc(1'b0, '0, 1'b1, tbl[i].cp[k], {t, "/commit"});
    if (tbl[i].fin) do_finish({t, "/finish"});
    chk({t, "/t_pass"}, 32'(pass), 32'(tbl[i].e_pass));
    chk({t, "/t_fail"}, 32'(fail), 32'(tbl[i].e_fail));
    chk({t, "/t_code"}, 32'(fail_code), 32'(tbl[i].e_code));
    chk({t, "/t_cnt"}, commit_cnt, tbl[i].e_cnt);
    chk({t, "/t_lvl"}, 32'(fifo_level), 32'(tbl[i].e_lvl));
    chk({t, "/t_mexp"}, mismatch_exp, tbl[i].e_mexp);
    chk({t, "/t_mgot"}, mismatch_got, tbl[i].e_mgot);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pcs[6];

    tbl[0] = '{3, '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 0},
               3, '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 0},
               1, 1, 0, 2'd0, 32'd3, 0, 0, 0};
    tbl[1] = '{2, '{32'h8000_0000, 32'h8000_0004, 0, 0},
               2, '{32'h8000_0000, 32'h8000_0010, 0, 0},
               0, 0, 1, 2'd1, 32'd1, 1,
               32'h8000_0004, 32'h8000_0010};
    tbl[2] = '{2, '{32'h10, 32'h20, 0, 0},
               3, '{32'h10, 32'h20, 32'h30, 0},
               0, 0, 1, 2'd2, 32'd2, 0, 0, 32'h30};
    tbl[3] = '{1, '{32'h100, 0, 0, 0},
               1, '{32'h104, 0, 0, 0},
               0, 0, 1, 2'd1, 32'd0, 1, 32'h100, 32'h104};
    tbl[4] = '{4, '{32'hA0, 32'hA4, 32'hA8, 32'hAC},
               4, '{32'hA0, 32'hA4, 32'hA8, 32'hAC},
               1, 1, 0, 2'd0, 32'd4, 0, 0, 0};

    for (int i = 0; i < 5; i++) run_vec(i);

    // Commits in IDLE are ignored; PASS is sticky.
    do_reset("idle/rst");
    cyc(1'b1, 32'h50, 1'b0, '0, "idle/push");
    cyc(1'b0, '0, 1'b1, 32'h50, "idle/commit");
    start_run("idle/start");
    cyc(1'b0, '0, 1'b1, 32'h50, "idle/match");
    do_finish("idle/finish");
    cyc(1'b1, 32'h60, 1'b1, 32'h99, "idle/sticky");

    // Watchdog: fail lands exactly 8 cycles after RUN is entered.
    do_reset("wd/rst");
    cyc(1'b1, 32'h1234, 1'b0, '0, "wd/push");
    start_run("wd/start");
    repeat (7) tick();
    chk("wd/early_fail", 32'(fail), 32'd0);
    chk("wd/early_busy", 32'(busy), 32'd1);
    tick();
    chk("wd/fail", 32'(fail), 32'd1);
    chk("wd/busy", 32'(busy), 32'd0);
    chk("wd/code", 32'(fail_code), 32'd3);
    chk("wd/mexp", mismatch_exp, 32'h1234);
    chk("wd/mgot", mismatch_got, 32'd0);

    // Commit on empty FIFO with a same-cycle push.
    do_reset("emp/rst");
    start_run("emp/start");
    cyc(1'b1, 32'h8000_0000, 1'b1, 32'h8000_0000, "emp/commit");

    // Full FIFO, blocked push, pointer wrap, six matches.
    do_reset("wrap/rst");
    for (int i = 0; i < 6; i++) pcs[i] = 32'h2000 + 32'(i * 4);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, pcs[i], 1'b0, '0, "wrap/push");
    start_run("wrap/start");
    cyc(1'b1, pcs[4], 1'b1, pcs[0], "wrap/c0");
    cyc(1'b1, pcs[4], 1'b1, pcs[1], "wrap/c1");
    cyc(1'b1, pcs[5], 1'b1, pcs[2], "wrap/c2");
    cyc(1'b0, '0, 1'b1, pcs[3], "wrap/c3");
    cyc(1'b0, '0, 1'b1, pcs[4], "wrap/c4");
    cyc(1'b0, '0, 1'b1, pcs[5], "wrap/c5");
    do_finish("wrap/finish");
    chk("wrap/pass", 32'(pass), 32'd1);
    chk("wrap/cnt", commit_cnt, 32'd6);

    // Reset mid-RUN with three entries left.
    do_reset("mid/rst");
    for (int i = 0; i < 4; i++)
      cyc(1'b1, pcs[i], 1'b0, '0, "mid/push");
    start_run("mid/start");
    cyc(1'b0, '0, 1'b1, pcs[0], "mid/c0");
    chk("mid/lvl3", 32'(fifo_level), 32'd3);
    do_reset("mid/reset");
    chk("mid/rdy", 32'(bus.exp_ready), 32'd1);
    chk("mid/cnt0", commit_cnt, 32'd0);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/difftest_commit_monitor.md
Name: difftest_commit_monitor

Overview:
- Simulation/FPGA-debug block on the consuming side of the core's difftest commit interface.
- Receives per-instruction commit pulses (commit_en, pc) from the core top.
- Checks each committed PC, in order, against an expected PC trace that a loader pushes into an internal FIFO.
- Reports pass/fail, failure cause, mismatch capture and commit count; a watchdog detects a hung pipeline.

Parameters:
DEPTH, 16, expected-PC FIFO entries (power of 2, >=2)
TIMEOUT, 1024, max cycles in RUN with no commit before timeout failure (>=2)

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
exp_valid  input  1  expected-PC push request
exp_pc  input  32  expected PC to push
exp_ready  output  1  FIFO can accept push
start  input  1  begin checking (pulse)
finish  input  1  trace complete indication (level)
commit_en  input  1  one instruction committed this cycle
commit_pc  input  32  PC of committed instruction
busy  output  1  state==RUN
pass  output  1  check passed (sticky)
fail  output  1  check failed (sticky)
fail_code  output  2  0 none, 1 PC mismatch, 2 commit with empty FIFO, 3 timeout
mismatch_exp  output  32  expected PC at failure
mismatch_got  output  32  committed PC at failure
commit_cnt  output  32  matched commits, saturating
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, synchronous on clk edge with resetn=0:
  - state=IDLE; FIFO empty; fifo_level=0.
  - busy=0, pass=0, fail=0, fail_code=0.
  - mismatch_exp=0, mismatch_got=0, commit_cnt=0; watchdog=0.
  - Reset mid-RUN discards all FIFO contents and status.
- FIFO:
  - exp_ready = (fifo_level<DEPTH) & state is IDLE or RUN.
  - Push when exp_valid & exp_ready; data is visible at head no earlier than the next cycle.
  - Pop only on a matched commit.
  - Push and pop in the same cycle: level unchanged. When full, exp_ready=0 even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE: pushes accepted; commit_en ignored and not counted. start -> RUN; watchdog cleared.
  - RUN, priority evaluated per cycle:
    1. commit_en & FIFO empty (at start of cycle; no bypass of a same-cycle push) -> FAIL, code 2, mismatch_got=commit_pc, mismatch_exp=0.
    2. commit_en & head!=commit_pc -> FAIL, code 1, capture head and commit_pc. No pop.
    3. commit_en & match -> pop, commit_cnt+1 (saturate at 32'hFFFFFFFF), watchdog cleared.
    4. No commit: watchdog+1. If watchdog==TIMEOUT-1 on this increment -> FAIL, code 3, mismatch_exp=head (0 if empty), mismatch_got=0.
    5. finish & FIFO empty & no commit this cycle -> PASS. finish with a non-empty FIFO keeps waiting; the watchdog eventually fires.
  - Commit and finish in the same cycle: the commit is processed; PASS is evaluated on a later cycle.
  - start while in RUN has no effect.
  - PASS and FAIL are terminal and sticky until reset. Pushes and commits are ignored; outputs hold.
- Timing:
  - All outputs are registered.
  - pass/fail/fail_code/captures update the cycle after the triggering edge; busy drops the same cycle.
  - Exactly one of pass/fail can ever be 1.
  - Throughput: one commit checked per cycle, back-to-back.

Test Plan:
- Push 8000_0000, 8000_0004, 8000_0008; start; commits with the same PCs on 3 consecutive cycles; finish -> pass=1, commit_cnt=3, fifo_level=0, fail=0.
- Push 8000_0000, 8000_0004; commits 8000_0000 then 8000_0010 -> fail=1, fail_code=1, mismatch_exp=8000_0004, mismatch_got=8000_0010, commit_cnt=1, fifo_level=1.
- TIMEOUT=8; push 1 PC; start, no commits -> fail with fail_code=3 exactly 8 cycles after start takes effect; mismatch_exp=pushed PC.
- Start with FIFO empty; commit_en with pc=8000_0000, alongside a simultaneous push -> fail_code=2, mismatch_got=8000_0000.
- DEPTH=4: push 5 PCs back-to-back -> exp_ready=0 after 4 pushes; 5th accepted only after the first matched commit; pointers wrap and 6 consecutive matches pass.
- Assert resetn=0 mid-RUN with fifo_level=3 -> next cycle all outputs 0, exp_ready=1; a fresh trace then passes.
